serial_add_scheduler: RTL and testbench

//  Shares one bit-serial 1-bit full-adder datapath between two requesters.

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/full_adder_1b.sv | 13 +
 rtl/serial_add_scheduler.sv | 135 +++++++++++++
 tb/tb_serial_add_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared encodings for the bit-serial add scheduler: FSM states and requester IDs.
package serial_add_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/full_adder_1b.sv
// One-bit combinational full adder; the only arithmetic in the serial datapath.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_scheduler.sv
// Round-robin shares one bit-serial full adder between two requesters; results
// leave LSB-first assembled on a valid/ready port tagged with the owner's ID.
module serial_add_scheduler
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               id_q, id_d;
  logic               ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic in_idle_c;
  logic grant0_c;
  logic grant1_c;
  logic accept_c;
  logic last_bit_c;
  logic fa_s;
  logic fa_cout;

  full_adder_1b u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Pointer breaks ties only; a lone valid requester always wins.
  assign in_idle_c  = (state_q == ST_IDLE);
  assign grant0_c   = in_idle_c && req0_valid && (!req1_valid || (ptr_q == REQ0));
  assign grant1_c   = in_idle_c && req1_valid && (!req0_valid || (ptr_q == REQ1));
  assign accept_c   = grant0_c || grant1_c;
  assign last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= REQ0;
      ptr_q   <= REQ0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept_c)   state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit_c) state_d = ST_DONE;
      ST_DONE:  if (res_ready)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operand capture on accept, then one sum bit per cycle entering at the MSB.
  always_comb begin : datapath
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          a_d     = grant0_c ? req0_a   : req1_a;
          b_d     = grant0_c ? req0_b   : req1_b;
          carry_d = grant0_c ? req0_cin : req1_cin;
          id_d    = grant0_c ? REQ0     : REQ1;
          ptr_d   = grant0_c ? REQ1     : REQ0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin : outputs
    req0_ready = grant0_c;
    req1_ready = grant1_c;
    res_valid  = (state_q == ST_DONE);
    busy       = !in_idle_c;
    res_sum    = sum_q;
    res_cout   = carry_q;
    res_id     = id_q;
  end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Directed self-checking bench for serial_add_scheduler (WIDTH=32).
module tb_serial_add_scheduler;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [31:0] req1_a, req1_b;
  logic        res_valid, res_ready, res_cout, res_id, busy;
  logic [31:0] res_sum;

  int checks;
  int failures;

  serial_add_scheduler #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_id     (res_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issues one op from the chosen requester; starts and ends at a negedge.
  task automatic run_op(input bit which, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input bit handshake,
                        output logic [31:0] sum, output logic cout, output logic id,
                        output int lat, output bit ok);
    int n;
    ok = 1'b1; lat = 0; n = 0;
    sum = '0; cout = 1'b0; id = 1'b0;
    if (which) begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
    end
    #1;
    while (!(which ? req1_ready : req0_ready) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 200) begin
      ok = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    while (!res_valid && lat < 200) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    if (!res_valid) begin
      ok = 1'b0;
      return;
    end
    sum = res_sum; cout = res_cout; id = res_id;
    if (handshake) begin
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({res_valid, busy, res_cout, res_id, req0_ready, req1_ready, res_sum} !== 38'd0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b busy=%b cout=%b id=%b rdy=%b%b sum=%h, want all 0",
               res_valid, busy, res_cout, res_id, req0_ready, req1_ready, res_sum);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] s; logic c, id; int lat; bit ok;
    run_op(1'b0, 32'hCCCCCCCC, 32'hAAAAAAAA, 1'b0, 1'b1, s, c, id, lat, ok);
    checks++;
    if (!ok || s !== 32'h77777776 || c !== 1'b1 || id !== 1'b0) begin
      failures++;
      $display("FAIL basic_req0: ok=%b sum=%h cout=%b id=%b, want sum=77777776 cout=1 id=0", ok, s, c, id);
    end
    checks++;
    if (lat !== 33) begin
      failures++;
      $display("FAIL basic_latency: got %0d cycles, want 33", lat);
    end
    run_op(1'b1, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 1'b1, s, c, id, lat, ok);
    checks++;
    if (!ok || s !== 32'h00000000 || c !== 1'b1 || id !== 1'b1) begin
      failures++;
      $display("FAIL basic_req1: ok=%b sum=%h cout=%b id=%b, want sum=00000000 cout=1 id=1", ok, s, c, id);
    end
  endtask

  task automatic test_round_robin();
    logic        exp_id;
    logic [31:0] exp_sum;
    int n;
    pulse_reset();
    req0_a = 32'd1;  req0_b = 32'd2;  req0_cin = 1'b0;
    req1_a = 32'd10; req1_b = 32'd20; req1_cin = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_id  = (k == 1) ? 1'b1 : 1'b0;
      exp_sum = exp_id ? 32'd31 : 32'd3;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== (exp_id ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL rr_grant_%0d: ready0/1=%b%b, want id %0d granted", k, req0_ready, req1_ready, exp_id);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({req0_ready, req1_ready, busy} !== 3'b001) begin
        failures++;
        $display("FAIL rr_busy_%0d: ready0/1=%b%b busy=%b, want 00 busy=1", k, req0_ready, req1_ready, busy);
      end
      n = 0;
      while (!res_valid && n < 100) begin
        @(negedge clk); n++;
      end
      checks++;
      if (!res_valid || res_id !== exp_id || res_sum !== exp_sum) begin
        failures++;
        $display("FAIL rr_result_%0d: valid=%b id=%b sum=%h, want valid=1 id=%b sum=%h",
                 k, res_valid, res_id, res_sum, exp_id, exp_sum);
      end
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] s; logic c, id; int lat; bit ok;
    run_op(1'b1, 32'h12345678, 32'h11111111, 1'b0, 1'b0, s, c, id, lat, ok);
    checks++;
    if (!ok || s !== 32'h23456789 || c !== 1'b0 || id !== 1'b1) begin
      failures++;
      $display("FAIL bp_result: ok=%b sum=%h cout=%b id=%b, want sum=23456789 cout=0 id=1", ok, s, c, id);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (res_valid !== 1'b1 || res_sum !== s || res_cout !== c || res_id !== id ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d: valid=%b sum=%h cout=%b id=%b rdy=%b%b, want held result, ready 00",
                 i, res_valid, res_sum, res_cout, res_id, req0_ready, req1_ready);
      end
      @(posedge clk);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: valid=%b busy=%b, want 0 0 (no accept on handshake edge)", res_valid, busy);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] s; logic c, id; int lat; bit ok;
    req0_a = 32'h0000FFFF; req0_b = 32'h00000001; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    while (!req0_ready) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({res_valid, busy, res_cout, res_id, req0_ready, req1_ready, res_sum} !== 38'd0) begin
      failures++;
      $display("FAIL midreset_outputs: valid=%b busy=%b cout=%b id=%b sum=%h, want all 0",
               res_valid, busy, res_cout, res_id, res_sum);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_noresult: valid=%b busy=%b, want 0 0", res_valid, busy);
    end
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, s, c, id, lat, ok);
    checks++;
    if (!ok || s !== 32'hFFFFFFFF || c !== 1'b1 || id !== 1'b0) begin
      failures++;
      $display("FAIL midreset_allones: ok=%b sum=%h cout=%b id=%b, want sum=ffffffff cout=1 id=0", ok, s, c, id);
    end
  endtask

  task automatic test_edges();
    logic [31:0] s; logic c, id; int lat; bit ok;
    run_op(1'b1, 32'h00000000, 32'h00000000, 1'b0, 1'b1, s, c, id, lat, ok);
    checks++;
    if (!ok || s !== 32'h0 || c !== 1'b0 || id !== 1'b1) begin
      failures++;
      $display("FAIL edge_zero: ok=%b sum=%h cout=%b id=%b, want sum=0 cout=0 id=1", ok, s, c, id);
    end
    run_op(1'b0, 32'h80000000, 32'h80000000, 1'b0, 1'b1, s, c, id, lat, ok);
    checks++;
    if (!ok || s !== 32'h0 || c !== 1'b1 || id !== 1'b0) begin
      failures++;
      $display("FAIL edge_msb: ok=%b sum=%h cout=%b id=%b, want sum=0 cout=1 id=0", ok, s, c, id);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_edges();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
